// File: rtl/systolic_pe_mac.sv
// Systolic MAC processing element: per-sample sequential signed multiply, TAPS-deep
// accumulation seeded by the upstream partial sum, one saturated word per frame.
module systolic_pe_mac #(
  parameter int WORDLENGTH = 16,
  parameter int TAPS       = 8,
  parameter int FRAC       = 15
) (
  input  logic                  clk30x,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDLENGTH-1:0] inputword,
  input  logic [WORDLENGTH-1:0] sum_in,
  input  logic                  coef_we,
  input  logic [5:0]            coef_addr,
  input  logic [WORDLENGTH-1:0] coef_data,
  output logic [WORDLENGTH-1:0] out_word,
  output logic                  out_valid,
  output logic                  out_sat,
  output logic [5:0]            tap_idx
);
  localparam int W  = WORDLENGTH;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 6;
  localparam int CW = $clog2(W + 1);
  localparam int TI = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;

  state_t              state;
  logic [W-1:0]        coef [TAPS];
  logic [PW-1:0]       mcand, prod;
  logic [W-1:0]        mplier;
  logic                neg;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        sum_lat;
  logic [AW-1:0]       acc;

  logic signed [PW-1:0] prod_s, p;
  logic [AW-1:0]        acc_nx;
  logic                 pos_ovf, neg_ovf;
  logic [W-1:0]         sat_word;

  // Magnitudes are W-bit unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  assign in_ready = (state == IDLE) && !reset;

  always_comb begin
    prod_s   = neg ? -$signed(prod) : $signed(prod);
    p        = prod_s >>> FRAC;
    acc_nx   = ((tap_idx == '0) ? {{(AW-W){sum_lat[W-1]}}, sum_lat} : acc)
             + {{(AW-PW){p[PW-1]}}, p};
    pos_ovf  = !acc_nx[AW-1] && (|acc_nx[AW-2:W-1]);
    neg_ovf  = acc_nx[AW-1] && !(&acc_nx[AW-2:W-1]);
    sat_word = acc_nx[W-1:0];
    if (pos_ovf) sat_word = {1'b0, {(W-1){1'b1}}};
    if (neg_ovf) sat_word = {1'b1, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk30x) begin
    if (reset) begin
      state     <= IDLE;
      tap_idx   <= '0;
      acc       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      sum_lat   <= '0;
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      // The accept below reads the pre-write coefficient on a same-cycle race.
      if (coef_we && ({1'b0, coef_addr} < 7'(TAPS)))
        coef[coef_addr[TI-1:0]] <= coef_data;
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= {{W{1'b0}}, mag(inputword)};
          mplier <= mag(coef[tap_idx[TI-1:0]]);
          neg    <= inputword[W-1] ^ coef[tap_idx[TI-1:0]][W-1];
          prod   <= '0;
          cnt    <= '0;
          if (tap_idx == '0) sum_lat <= sum_in;
          state  <= MULT;
        end
        MULT: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= ACC;
        end
        ACC: begin
          acc <= acc_nx;
          if (tap_idx == 6'(TAPS - 1)) begin
            out_word  <= sat_word;
            out_sat   <= pos_ovf || neg_ovf;
            out_valid <= 1'b1;
            tap_idx   <= '0;
          end else begin
            tap_idx <= tap_idx + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_pe_mac.sv
// Randomized frame-level bench for systolic_pe_mac against a plain-arithmetic reference.
module tb_systolic_pe_mac;
  localparam int W = 16, TAPS = 4, FRAC = 15;

  logic          clk30x = 1'b0, reset = 1'b1, in_valid = 1'b0, coef_we = 1'b0;
  logic [W-1:0]  inputword = '0, sum_in = '0, coef_data = '0;
  logic [5:0]    coef_addr = '0;
  logic          in_ready, out_valid, out_sat;
  logic [W-1:0]  out_word;
  logic [5:0]    tap_idx;

  systolic_pe_mac #(.WORDLENGTH(W), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk30x(clk30x), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inputword(inputword), .sum_in(sum_in), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_word(out_word), .out_valid(out_valid), .out_sat(out_sat),
    .tap_idx(tap_idx));

  always #5 clk30x = ~clk30x;

  int cyc = 0;
  always @(posedge clk30x) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int npulse = 0, out_cyc = 0, acc_cyc = 0, acc_cyc_prev = 0;
  logic [W-1:0] last_word = '0;
  logic         last_sat = 1'b0;

  always @(negedge clk30x) if (out_valid) begin
    npulse++; out_cyc = cyc; last_word = out_word; last_sat = out_sat;
  end

  logic [W-1:0] mc  [TAPS];
  logic [W-1:0] smp [TAPS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame result straight from the arithmetic definition: floor-shifted products plus sum_in.
  function automatic logic [W:0] model(input logic [W-1:0] si);
    longint a;
    a = longint'($signed(si));
    for (int t = 0; t < TAPS; t++)
      a += (longint'($signed(smp[t])) * longint'($signed(mc[t]))) >>> FRAC;
    if (a > 32767)  return {1'b1, 16'h7FFF};
    if (a < -32768) return {1'b1, 16'h8000};
    return {1'b0, a[15:0]};
  endfunction

  task automatic write_coef(input logic [5:0] a, input logic [W-1:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk30x); #1;
    coef_we = 1'b0;
    if (a < TAPS) mc[a] = d;
  endtask

  task automatic set_all(input logic [W-1:0] d);
    for (int t = 0; t < TAPS; t++) write_coef(6'(t), d);
  endtask

  task automatic send(input logic [W-1:0] s, input logic [W-1:0] si, input int t,
                      input bit hold, input bit race);
    inputword = s; sum_in = si; in_valid = 1'b1;
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk30x);
    chk("ready_wait", {63'd0, in_ready}, 64'd1);
    chk($sformatf("tap_idx_%0d", t), 64'(tap_idx), 64'(t));
    if (race) begin coef_we = 1'b1; coef_addr = 6'd1; coef_data = 16'h7FFF; end
    acc_cyc_prev = acc_cyc; acc_cyc = cyc;
    if (hold && t > 0) chk("accept_spacing", 64'(acc_cyc - acc_cyc_prev), 64'(W + 2));
    @(negedge clk30x); #1;
    coef_we = 1'b0;
    if (hold) begin
      // Junk on the bus while busy must never be taken.
      inputword = 16'($urandom); sum_in = 16'($urandom);
      repeat (5) @(negedge clk30x);
    end else in_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [W-1:0] si, input bit hold, input bit race);
    logic [W:0] e;
    int np0;
    e = model(si);
    np0 = npulse;
    for (int t = 0; t < TAPS; t++) begin
      if (t == TAPS - 1) chk({tag, "_early"}, 64'(npulse), 64'(np0));
      send(smp[t], (t == 0) ? si : 16'($urandom), t, hold, race && t == 1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && npulse == np0; k++) begin @(negedge clk30x); #1; end
    repeat (3) @(negedge clk30x);
    #1;
    chk({tag, "_pulses"}, 64'(npulse - np0), 64'd1);
    chk({tag, "_lat"}, 64'(out_cyc - acc_cyc), 64'(W + 2));
    chk({tag, "_word"}, 64'(last_word), 64'(e[W-1:0]));
    chk({tag, "_sat"}, 64'(last_sat), 64'(e[W]));
    if (race) mc[1] = 16'h7FFF;
  endtask

  initial begin
    int np0;
    logic signed [W-1:0] r;
    for (int t = 0; t < TAPS; t++) mc[t] = '0;
    repeat (3) @(negedge clk30x);
    chk("rst_ready_low", {63'd0, in_ready}, 64'd0);
    reset = 1'b0; #1;
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_tap", 64'(tap_idx), 64'd0);
    chk("rst_word", 64'(out_word), 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sat", {63'd0, out_sat}, 64'd0);

    set_all(16'h4000);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h2000;
    frame("basic", 16'h0000, 0, 0);
    set_all(16'h7FFF);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h7FFF;
    frame("pos_sat", 16'h0000, 0, 0);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h8000;
    frame("neg_sat", 16'h0000, 0, 0);
    set_all(16'h0000);
    write_coef(6'd0, 16'h0001);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'hFFFF;
    frame("trunc", 16'h0010, 0, 0);
    write_coef(6'd0, 16'h8000);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h8000;
    frame("extreme", 16'h0000, 0, 0);

    for (int t = 0; t < TAPS; t++) begin
      write_coef(6'(t), 16'($urandom)); r = 16'($urandom); smp[t] = r >>> 2;
    end
    frame("hold", 16'($urandom), 1, 0);

    set_all(16'h4000);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h4000;
    frame("race", 16'h0000, 0, 1);
    frame("post_race", 16'h0000, 0, 0);
    write_coef(6'd5, 16'h1234);
    frame("addr5", 16'h0100, 0, 0);

    for (int f = 0; f < 16; f++) begin
      for (int n = 0; n < 3; n++) write_coef(6'($urandom_range(0, 7)), 16'($urandom));
      for (int t = 0; t < TAPS; t++) begin
        r = 16'($urandom); smp[t] = r >>> $urandom_range(0, 4);
      end
      frame($sformatf("rnd%0d", f), 16'($urandom), bit'($urandom_range(0, 1)), 0);
    end

    // Abort a frame mid-multiply at tap 2.
    set_all(16'h4000);
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h2000;
    frame("pre_rst", 16'h1000, 0, 0);
    for (int t = 0; t < 3; t++) send(16'h2000, 16'h0000, t, 0, 0);
    repeat (4) @(negedge clk30x);
    reset = 1'b1; coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'h7FFF;
    #1;
    chk("mid_rst_ready_low", {63'd0, in_ready}, 64'd0);
    @(negedge clk30x);
    reset = 1'b0; coef_we = 1'b0;
    for (int t = 0; t < TAPS; t++) mc[t] = '0;
    #1;
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_tap", 64'(tap_idx), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    chk("mid_rst_sat", {63'd0, out_sat}, 64'd0);
    np0 = npulse;
    repeat (30) @(negedge clk30x);
    #1;
    chk("mid_rst_no_pulse", 64'(npulse), 64'(np0));
    for (int t = 0; t < TAPS; t++) smp[t] = 16'h7000;
    frame("after_rst", 16'h1234, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
